// File: rtl/mips_fetch_pkg.sv
// Purpose: shared types and constants for the MIPS fetch stage (bubble word, fetch entry, redirect select).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_fetch_pkg;

    // Width of the fields carried in a fetch entry; the fetch unit's NB_BITS is expected to match.
    localparam int FETCH_NB_BITS = 32;

    // sll $0,$0,0 -- the canonical pipeline bubble.
    localparam logic [FETCH_NB_BITS-1:0] MIPS_NOP = 32'h0000_0000;

    // One prefetched instruction together with the PC+4 that decode expects alongside it.
    typedef struct packed {
        logic [FETCH_NB_BITS-1:0] pc4;
        logic [FETCH_NB_BITS-1:0] instr;
    } fetch_entry_t;

    // Which redirect source steers the next fetch; a jump outranks a taken branch.
    typedef enum logic [1:0] {
        REDIR_NONE = 2'b00,
        REDIR_BRQ  = 2'b01,
        REDIR_JMP  = 2'b10
    } redir_sel_t;

    function automatic redir_sel_t redir_select(input logic jmp, input logic beq);
        if (jmp) begin
            return REDIR_JMP;
        end
        if (beq) begin
            return REDIR_BRQ;
        end
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/Single_port_ram.sv
// Purpose: single-port instruction RAM, one read or write per cycle.
// Latency: read data registered, valid one clock after i_re.
// Backpressure: none; the caller arbitrates the single port.
module Single_port_ram #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic               i_re,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic [NB_DATA-1:0] o_rdata
);

    logic [NB_DATA-1:0] r_mem [2**NB_ADDR];
    logic [NB_DATA-1:0] r_rdata;

    // Write-or-read storage array; read data holds until the next read strobe.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fetch_prefetch_fifo.sv
// Purpose: small prefetch queue between instruction-RAM responses and the IF/ID register.
// Latency: a pushed entry is visible at o_head one clock after the push (no bypass).
// Backpressure: none internally; the producer must never push when full (fetch issue is gated on level).
module fetch_prefetch_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_push_dat,
    input  logic                          i_pop,
    input  logic                          i_clear,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic [WIDTH-1:0]              o_head
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_pop;

    // A pop on an empty queue is ignored so the pointers can never skew.
    assign w_pop = i_pop && (r_level != '0);

    // Pointer and occupancy tracking; clear discards everything including a same-cycle push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is meaningful.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Purpose: MIPS IF stage -- PC generation, instruction-RAM reads, prefetch queue and IF/ID register; optional perf counters under FETCH_PERF_CNT_EN.
// Latency: fetch issued at edge N is queued at N+1 and can enter IF/ID at N+2; 1 instr/cycle steady state.
// Backpressure: i_if_id_we=0 stalls IF/ID; fetching stops once queued plus in-flight entries reach FIFO_DEPTH.
module fetch_prefetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                  NB_BITS    = 32,
    parameter int                  RAM_AW     = 10,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [NB_BITS-1:0]  RESET_PC   = '0,
    parameter logic [NB_BITS-1:0]  NOP_INSTR  = MIPS_NOP
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NB_BITS-1:0]            i_brq_addr,
    input  logic [NB_BITS-1:0]            i_jmp_addr,
    input  logic                          i_ctr_beq,
    input  logic                          i_ctr_jmp,
    input  logic                          i_ctr_flush,
    input  logic                          i_if_id_we,
    input  logic                          i_halt,
    input  logic                          i_du_we,
    input  logic [RAM_AW-1:0]             i_du_addr,
    input  logic [NB_BITS-1:0]            i_du_data,
    output logic [NB_BITS-1:0]            o_if_id_pc,
    output logic [NB_BITS-1:0]            o_if_id_instr,
    output logic                          o_if_id_valid,
    output logic [NB_BITS-1:0]            o_fetch_pc,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [NB_BITS-1:0]            o_cnt_fetched,
    output logic [NB_BITS-1:0]            o_cnt_squashed
);

    localparam int             LW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW:0]    OCC_MAX = (LW + 1)'(FIFO_DEPTH);

    logic [NB_BITS-1:0] r_fetch_pc;
    logic [NB_BITS-1:0] r_tag;
    logic               r_inflight;
    logic [NB_BITS-1:0] r_if_id_pc;
    logic [NB_BITS-1:0] r_if_id_instr;
    logic               r_if_id_valid;

    redir_sel_t         w_redir_sel;
    logic               w_redirect;
    logic [NB_BITS-1:0] w_target;
    logic [LW-1:0]      w_level;
    logic [LW:0]        w_occ;
    logic               w_empty;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    fetch_entry_t       w_push_dat;
    fetch_entry_t       w_head;
    logic               w_ram_we;
    logic [RAM_AW-1:0]  w_ram_addr;
    logic [NB_BITS-1:0] w_ram_rdata;

    assign w_redir_sel = redir_select(i_ctr_jmp, i_ctr_beq);
    assign w_redirect  = (w_redir_sel != REDIR_NONE);

    // Redirect target: jump address when a jump is requested, branch target otherwise.
    always_comb begin
        w_target = i_brq_addr;
        if (w_redir_sel == REDIR_JMP) begin
            w_target = i_jmp_addr;
        end
    end

    // Slots already promised (queued + in flight) bound how far fetch may run ahead.
    assign w_occ   = {1'b0, w_level} + {{LW{1'b0}}, r_inflight};
    assign w_empty = (w_level == '0);
    assign w_issue = !i_halt && !w_redirect && (w_occ < OCC_MAX);

    // A redirect at the response edge squashes the returning word.
    assign w_push     = r_inflight && !w_redirect;
    assign w_pop      = !w_redirect && !i_ctr_flush && i_if_id_we && !w_empty;
    assign w_push_dat = '{pc4: r_tag, instr: w_ram_rdata};

    // Single RAM port: debug writes own it while halted, fetch reads otherwise.
    assign w_ram_we   = i_halt && i_du_we;
    assign w_ram_addr = i_halt ? i_du_addr : r_fetch_pc[RAM_AW+1:2];

    Single_port_ram #(
        .NB_DATA (NB_BITS),
        .NB_ADDR (RAM_AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_re    (w_issue),
        .i_addr  (w_ram_addr),
        .i_wdata (i_du_data),
        .o_rdata (w_ram_rdata)
    );

    fetch_prefetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      ($bits(fetch_entry_t))
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_clear    (w_redirect),
        .o_level    (w_level),
        .o_head     (w_head)
    );

    // PC generation and the in-flight read tracker; the tag rides alongside the pending RAM read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_tag      <= '0;
            r_inflight <= 1'b0;
        end else if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag      <= r_fetch_pc + NB_BITS'(4);
                r_fetch_pc <= r_fetch_pc + NB_BITS'(4);
            end
        end
    end

    // IF/ID register: redirect and flush insert a bubble, otherwise pop when advancing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (w_redirect || i_ctr_flush) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (i_if_id_we) begin
            if (!w_empty) begin
                r_if_id_pc    <= w_head.pc4;
                r_if_id_instr <= w_head.instr;
                r_if_id_valid <= 1'b1;
            end else begin
                r_if_id_instr <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [NB_BITS-1:0] r_cnt_fetched;
    logic [NB_BITS-1:0] r_cnt_squashed;

    // Count delivered instructions and every queued or in-flight word thrown away by a redirect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_fetched  <= '0;
            r_cnt_squashed <= '0;
        end else begin
            if (w_pop) begin
                r_cnt_fetched <= r_cnt_fetched + NB_BITS'(1);
            end
            if (w_redirect) begin
                r_cnt_squashed <= r_cnt_squashed + NB_BITS'(w_occ);
            end
        end
    end

    assign o_cnt_fetched  = r_cnt_fetched;
    assign o_cnt_squashed = r_cnt_squashed;
`else
    assign o_cnt_fetched  = '0;
    assign o_cnt_squashed = '0;
`endif

    assign o_if_id_pc    = r_if_id_pc;
    assign o_if_id_instr = r_if_id_instr;
    assign o_if_id_valid = r_if_id_valid;
    assign o_fetch_pc    = r_fetch_pc;
    assign o_fifo_level  = w_level;

endmodule
